// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI4 bus bundle (AW/W/B/AR/R channels) between a memory initiator and responder
interface axi_mem_slave_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-outstanding AXI4 responder over a word-addressed memory with INCR bursts and byte strobes
module axi_mem_slave #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024
) (
    input logic              clk,
    input logic              reset,
    axi_mem_slave_if.slave   bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(STRB_WIDTH);
    localparam int MA         = $clog2(MEM_DEPTH);
    localparam int IW         = ADDR_WIDTH - OFF + 1;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    prio_rd;
    logic                    err;
    logic [ADDR_WIDTH-OFF-1:0] base;
    logic [7:0]              len;
    logic [7:0]              cnt;
    logic                    grant_w, grant_r, w_hs, r_hs;
    logic [IW-1:0]           w_idx, r_idx;
    logic                    w_ok, r_ok, w_final, r_final;

    // Arbitration, ready/valid outputs and beat addressing; the word index keeps one extra bit so base+beat never wraps
    always_comb begin
        grant_r     = reset && state == IDLE && bus.arvalid && (!bus.awvalid || prio_rd);
        grant_w     = reset && state == IDLE && bus.awvalid && !grant_r;
        bus.arready = grant_r;
        bus.awready = grant_w;
        bus.wready  = grant_w || (reset && state == WR_DATA);
        bus.bvalid  = state == WR_RESP;
        bus.bresp   = (state == WR_RESP && err) ? 2'b10 : 2'b00;
        bus.rvalid  = state == RD_DATA;
        w_hs        = bus.wvalid && bus.wready;
        r_hs        = bus.rvalid && bus.rready;
        w_idx       = (state == IDLE) ? {1'b0, bus.awaddr[ADDR_WIDTH-1:OFF]} : {1'b0, base} + IW'(cnt);
        w_final     = (state == IDLE) ? (bus.awlen == 8'd0) : (cnt == len);
        r_idx       = grant_r ? {1'b0, bus.araddr[ADDR_WIDTH-1:OFF]} : {1'b0, base} + IW'(cnt + 8'd1);
        r_final     = grant_r ? (bus.arlen == 8'd0) : ((cnt + 8'd1) == len);
        w_ok        = w_idx < IW'(MEM_DEPTH);
        r_ok        = r_idx < IW'(MEM_DEPTH);
    end

    // Next-state: a write whose only beat arrives with AW goes straight to the response
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = grant_r ? RD_DATA : grant_w ? ((w_hs && w_final) ? WR_RESP : WR_DATA) : IDLE;
            WR_DATA: state_n = (w_hs && w_final) ? WR_RESP : WR_DATA;
            WR_RESP: state_n = bus.bready ? IDLE : WR_RESP;
            RD_DATA: state_n = (bus.rready && bus.rlast) ? IDLE : RD_DATA;
            default: state_n = IDLE;
        endcase
    end

    // Transaction context, error flag and registered read beat; the next beat is fetched on each R handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            prio_rd   <= 1'b1;
            err       <= 1'b0;
            base      <= '0;
            len       <= '0;
            cnt       <= '0;
            bus.bid   <= '0;
            bus.rid   <= '0;
            bus.rdata <= '0;
            bus.rresp <= 2'b00;
            bus.rlast <= 1'b0;
        end else begin
            state <= state_n;
            if (grant_r) prio_rd <= 1'b0;
            else if (grant_w) prio_rd <= 1'b1;
            if (grant_w) begin
                bus.bid <= bus.awid;
                base    <= bus.awaddr[ADDR_WIDTH-1:OFF];
                len     <= bus.awlen;
                cnt     <= w_hs ? 8'd1 : 8'd0;
            end else if (grant_r) begin
                bus.rid <= bus.arid;
                base    <= bus.araddr[ADDR_WIDTH-1:OFF];
                len     <= bus.arlen;
                cnt     <= 8'd0;
            end else if (w_hs || r_hs) begin
                cnt <= cnt + 8'd1;
            end
            if (state == WR_RESP && bus.bready) err <= 1'b0;
            else if (w_hs && (!w_ok || bus.wlast != w_final)) err <= 1'b1;
            if (grant_r || (r_hs && !bus.rlast)) begin
                bus.rdata <= r_ok ? mem[r_idx[MA-1:0]] : '0;
                bus.rresp <= r_ok ? 2'b00 : 2'b10;
                bus.rlast <= r_final;
            end
        end
    end

    // Byte-strobed memory write; out-of-range beats are dropped and reset blocks a write on its edge
    always_ff @(posedge clk) begin
        if (reset && w_hs && w_ok) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (bus.wstrb[i]) mem[w_idx[MA-1:0]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized AXI traffic checked every cycle against a queue-based memory model
module tb_axi_mem_slave;
    typedef struct { logic [12:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [12:0] id; logic [1:0] resp; } b_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int r_pops = 0;
    logic [63:0] mm [1024];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] rd_cap [256];
    logic [1:0]  rr_cap [256];
    logic        last_same;
    logic [1:0]  last_bresp;
    r_exp_t exp_r [$];
    b_exp_t exp_b [$];

    axi_mem_slave_if bus ();

    axi_mem_slave dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every presented R and B beat against the model queues
    always @(negedge clk) begin
        if (bus.rvalid) begin
            if (exp_r.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL r_unexpected: got rvalid=1 expected no beat");
            end else begin
                check("r_data", bus.rdata, exp_r[0].data);
                check("r_resp", 64'(bus.rresp), 64'(exp_r[0].resp));
                check("r_last", 64'(bus.rlast), 64'(exp_r[0].last));
                check("r_id", 64'(bus.rid), 64'(exp_r[0].id));
                if (bus.rready) begin void'(exp_r.pop_front()); r_pops++; end
            end
        end
        if (bus.bvalid) begin
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected: got bvalid=1 expected no response");
            end else begin
                check("b_id", 64'(bus.bid), 64'(exp_b[0].id));
                check("b_resp", 64'(bus.bresp), 64'(exp_b[0].resp));
                if (bus.bready) void'(exp_b.pop_front());
            end
        end
        if (!reset) begin exp_r.delete(); exp_b.delete(); end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic bit wl_of(int k, int len, int early);
        return (early >= 0) ? (k == early) : (k == len);
    endfunction

    task automatic model_write(input logic [12:0] id, input logic [63:0] addr, input int len, input int early);
        logic [64:0] idx;
        bit e = 0;
        for (int k = 0; k <= len; k++) begin
            idx = {1'b0, addr >> 3} + 65'(k);
            if (wl_of(k, len, early) != (k == len)) e = 1;
            if (idx < 65'd1024) begin
                for (int b = 0; b < 8; b++) if (ws[k][b]) mm[idx[9:0]][8*b +: 8] = wd[k][8*b +: 8];
            end else e = 1;
        end
        exp_b.push_back('{id, e ? 2'b10 : 2'b00});
    endtask

    task automatic model_read(input logic [12:0] id, input logic [63:0] addr, input int len);
        logic [64:0] idx;
        for (int k = 0; k <= len; k++) begin
            idx = {1'b0, addr >> 3} + 65'(k);
            if (idx < 65'd1024) exp_r.push_back('{id, mm[idx[9:0]], 2'b00, k == len});
            else exp_r.push_back('{id, 64'd0, 2'b10, k == len});
        end
    endtask

    task automatic do_write(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int early, input bit aw_first, input int gap, input int bhold);
        bit aw_done = 0, w_on = 0, hs_aw, hs_w;
        int k = 0, cyc = 0;
        model_write(id, addr, len, early);
        last_same = 1'b0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
        while ((!aw_done || k <= len) && cyc < 3000) begin
            if (!w_on && k <= len && !(aw_first && !aw_done) && $urandom_range(99) >= gap) w_on = 1;
            bus.wvalid = w_on;
            if (k <= len) begin
                bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = wl_of(k, len, early);
            end
            @(negedge clk);
            hs_aw = bus.awvalid && bus.awready;
            hs_w = bus.wvalid && bus.wready;
            if (hs_aw && hs_w) last_same = 1'b1;
            @(posedge clk); #1; cyc++;
            if (hs_aw) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (hs_w) begin k++; w_on = 0; end
        end
        bus.wvalid = 1'b0; bus.awvalid = 1'b0;
        check("w_timeout", 64'(aw_done && k > len), 64'd1);
        for (int i = 0; i <= bhold; i++) begin
            bus.bready = (i == bhold);
            @(negedge clk);
            check("b_valid_held", 64'(bus.bvalid), 64'd1);
            if (i == bhold) last_bresp = bus.bresp;
            @(posedge clk); #1;
        end
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len, input int rpct);
        bit hs = 0, first = 1;
        int k = 0, cyc = 0;
        model_read(id, addr, len);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
        while (!hs && cyc < 50) begin
            @(negedge clk); hs = bus.arready;
            @(posedge clk); #1; cyc++;
        end
        bus.arvalid = 1'b0;
        check("ar_timeout", 64'(hs), 64'd1);
        while (k <= len && cyc < 3000) begin
            bus.rready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (first) begin check("r_valid_after_ar", 64'(bus.rvalid), 64'd1); first = 0; end
            if (bus.rvalid && bus.rready) begin rd_cap[k] = bus.rdata; rr_cap[k] = bus.rresp; k++; end
            @(posedge clk); #1; cyc++;
        end
        bus.rready = 1'b0;
        check("r_timeout", 64'(k > len), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, 64'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}), 64'd0);
        check({tag, "_rdata"}, bus.rdata, 64'd0);
        check({tag, "_ids"}, 64'({bus.bid, bus.rid, bus.bresp, bus.rresp}), 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        int m = $urandom_range(9);
        logic [63:0] w, a;
        w = 64'($urandom_range(1023));
        if (m == 7) w = 64'($urandom_range(1023, 1016));
        if (m == 8) w = 64'($urandom_range(1100, 1024));
        a = (w << 3) | 64'($urandom_range(7));
        if (m == 9) a = a | (64'd1 << $urandom_range(63, 40));
        return a;
    endfunction

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1; reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 256; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
            do_write(13'(i), 64'(i * 2048), 8'd255, -1, 1'b0, 0, 0);
        end

        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(13'h0123, 64'h40, 8'd0, -1, 1'b0, 0, 0);
        check("t1_aw_w_same_cycle", 64'(last_same), 64'd1);
        check("t1_bresp", 64'(last_bresp), 64'd0);
        check("t1_model_pin", mm[8], 64'h1122334455667788);
        do_read(13'h0456, 64'h40, 8'd0, 100);
        check("t1_rdata", rd_cap[0], 64'h1122334455667788);

        wd[0] = 64'hAAAAAAAABBBBBBBB; ws[0] = 8'h0F;
        do_write(13'h0124, 64'h40, 8'd0, -1, 1'b0, 0, 0);
        do_read(13'h0457, 64'h40, 8'd0, 100);
        check("t2_rdata", rd_cap[0], 64'h11223344BBBBBBBB);

        for (int k = 0; k < 4; k++) begin wd[k] = 64'(k + 1); ws[k] = 8'hFF; end
        do_write(13'h0200, 64'h100, 8'd3, -1, 1'b1, 50, 0);
        check("t3_bresp", 64'(last_bresp), 64'd0);
        do_read(13'h0201, 64'h100, 8'd3, 50);
        for (int k = 0; k < 4; k++) check("t3_burst_rdata", rd_cap[k], 64'(k + 1));

        wd[0] = 64'hDEADBEEFCAFEF00D; ws[0] = 8'hFF;
        do_write(13'h0300, 64'h2000, 8'd0, -1, 1'b0, 0, 0);
        check("t4_oor_bresp", 64'(last_bresp), 64'd2);
        do_read(13'h0301, 64'h2000, 8'd0, 100);
        check("t4_oor_rdata", rd_cap[0], 64'd0);
        check("t4_oor_rresp", 64'(rr_cap[0]), 64'd2);
        do_read(13'h0302, 64'h0, 8'd0, 100);
        do_read(13'h0303, 64'h1FF8, 8'd0, 100);
        wd[0] = 64'h1; wd[1] = 64'h2; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(13'h0304, 64'h200, 8'd1, 0, 1'b0, 0, 0);
        check("t4_early_wlast_bresp", 64'(last_bresp), 64'd2);
        do_read(13'h0305, 64'h200, 8'd1, 100);

        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        begin
            int cyc = 0, pops0;
            bit got = 0;
            wd[0] = 64'h0BADC0DE12345678; ws[0] = 8'hFF;
            model_read(13'h0055, 64'h40, 0);
            model_write(13'h00AA, 64'h48, 0, -1);
            bus.awid = 13'h00AA; bus.awaddr = 64'h48; bus.awlen = 8'd0; bus.awvalid = 1'b1;
            bus.wdata = wd[0]; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
            bus.arid = 13'h0055; bus.araddr = 64'h40; bus.arlen = 8'd0; bus.arvalid = 1'b1;
            bus.rready = 1'b1;
            pops0 = r_pops;
            @(negedge clk);
            check("t5_read_granted", 64'({bus.arready, bus.awready, bus.wready}), 64'b100);
            @(posedge clk); #1; bus.arvalid = 1'b0;
            while (!got && cyc < 20) begin
                @(negedge clk); got = bus.awready && bus.wready;
                if (got) check("t5_read_before_write", 64'(r_pops - pops0), 64'd1);
                @(posedge clk); #1; cyc++;
            end
            check("t5_write_granted", 64'(got), 64'd1);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.rready = 1'b0;
            for (int i = 0; i <= 5; i++) begin
                bus.bready = (i == 5);
                @(negedge clk);
                check("t5_bvalid_held", 64'(bus.bvalid), 64'd1);
                check("t5_bid_held", 64'(bus.bid), 64'h00AA);
                @(posedge clk); #1;
            end
            bus.bready = 1'b0;
        end

        begin
            int k = 0, cyc = 0;
            bit hs = 0;
            model_read(13'h0600, 64'h100, 3);
            bus.arid = 13'h0600; bus.araddr = 64'h100; bus.arlen = 8'd3; bus.arvalid = 1'b1;
            while (!hs && cyc < 20) begin
                @(negedge clk); hs = bus.arready;
                @(posedge clk); #1; cyc++;
            end
            bus.arvalid = 1'b0; bus.rready = 1'b1;
            while (k < 1 && cyc < 40) begin
                @(negedge clk); if (bus.rvalid && bus.rready) k++;
                @(posedge clk); #1; cyc++;
            end
            check("t6_beats_before_reset", 64'(k), 64'd1);
            reset = 1'b0; bus.rready = 1'b0;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            check_reset_outputs("t6_abort");
            @(posedge clk); #1; reset = 1'b1;
            do_read(13'h0601, 64'h108, 8'd0, 100);
            check("t6_after_reset_rdata", rd_cap[0], 64'd2);
        end

        for (int n = 0; n < 80; n++) begin
            logic [7:0] len;
            int early;
            len = 8'($urandom_range(7));
            if ($urandom_range(1) == 0) begin
                for (int k = 0; k < 8; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom_range(255)); end
                early = ($urandom_range(5) == 0) ? int'($urandom_range(32'(len))) : -1;
                do_write(13'($urandom), rand_addr(), len, early, 1'($urandom_range(1)),
                         int'($urandom_range(60)), int'($urandom_range(3)));
            end else begin
                do_read(13'($urandom), rand_addr(), len, int'($urandom_range(100, 30)));
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        check("final_r_queue_empty", 64'(exp_r.size()), 64'd0);
        check("final_b_queue_empty", 64'(exp_b.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_mem_slave.md
Name:
axi_mem_slave

Overview:
AXI4 responder backed by an internal word-addressed memory array. It serves as the memory-side endpoint for the data-memory AXI initiator in CPU simulation and FPGA builds. It supports single-beat and INCR bursts at full data width, byte strobes, and one outstanding transaction at a time.

Parameters:
ID_WIDTH, 13, width of all AXI ID fields
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, data bus width; STRB_WIDTH = DATA_WIDTH/8 is derived
MEM_DEPTH, 1024, number of DATA_WIDTH-bit words

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats minus 1
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STRB_WIDTH  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  response ID
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  beats minus 1
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  read ID
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset: sampled at a rising edge with reset=0. State goes to IDLE. All valid/ready outputs, bid, rid, bresp, rresp, rdata and rlast are 0. Arbitration priority is set to read. Memory contents are not cleared. Reset mid-transaction aborts it, and any partial write beats already stored stay stored.
- States: IDLE, WR_DATA, WR_RESP, RD_DATA. awready and arready are high only in IDLE.
- Arbitration in IDLE:
  - If only one of awvalid/arvalid is high, that one is granted.
  - If both are high, the type not granted last is granted.
  - awready = grant_w. arready = grant_r.
- Write accept in IDLE:
  - With the write granted, wready = 1 in the same cycle, so AW and the first W beat may handshake together.
  - AW latches id, address and len.
  - If the first W beat is taken, go to WR_RESP when len=0, else WR_DATA. If no W beat is taken, go to WR_DATA.
- WR_DATA: wready = 1. Each beat handshake increments the beat counter. Next-state rule:
  - Final beat when count == awlen; then go to WR_RESP.
  - wlast is ignored for termination.
- Beat addressing:
  - Beat k uses word index = (start_addr >> log2(STRB_WIDTH)) + k.
  - Low address bits are ignored (accesses are treated as aligned).
  - In-range means index < MEM_DEPTH.
- Write commit: for each i with wstrb[i]=1, byte i of mem[index] takes wdata byte i, on the handshake edge.
- Write errors:
  - An out-of-range beat is dropped and sets the SLVERR flag.
  - A wlast mismatch sets the SLVERR flag. Mismatch means wlast=1 before the final beat, or wlast=0 on it.
- WR_RESP:
  - bvalid = 1, bid = latched awid, bresp = 10 if the flag is set, else 00.
  - Outputs hold stable until bready; then go to IDLE and clear the flag.
- Read:
  - An AR handshake at edge N gives rvalid = 1 after edge N, with registered rdata/rresp/rlast for beat 0. State is RD_DATA.
  - Each R handshake loads the next beat on that edge.
  - rlast = 1 only on beat arlen.
  - All R outputs hold stable while rready = 0.
  - The handshake on the rlast beat returns to IDLE with rvalid = 0.
  - An out-of-range beat returns rdata = 0 and rresp = 10. In-range beats return rresp = 00.
- Throughput: at least one idle cycle between transactions.
- Width rules: the index computation must not overflow for ADDR_WIDTH = 64. Upper address bits are compared, not truncated.

Test Plan:
- Write 0x1122334455667788 to 0x40, wstrb 0xFF, AW and W valid together. Required: awready and wready high in the same cycle; bvalid the next cycle with bresp 00 and matching bid. Read 0x40: rvalid 1 cycle after AR, rdata 0x1122334455667788, rlast 1.
- Overwrite 0x40 with wdata 0xAAAAAAAABBBBBBBB, wstrb 0x0F. Read 0x40 returns 0x11223344BBBBBBBB.
- Burst write awlen=3 at 0x100, values 1,2,3,4, with wvalid gaps and W after AW. Then burst read arlen=3 with rready toggling. Required: 1,2,3,4 in order; rlast only on beat 4; data stable during stalls.
- Write to byte address MEM_DEPTH*8 returns bresp 10 and memory is unchanged. Read there returns rdata 0, rresp 10. A write with wlast early at awlen=1 returns bresp 10.
- awvalid and arvalid asserted together right after reset: read is granted first, then write. Hold bready low 5 cycles: bvalid and bid stay held.
- Pull reset low during beat 2 of a 4-beat read. The next cycle all outputs are 0. A new single read then completes normally.
